// File: rtl/idu_rf_prf_pkg.sv
// Shared IDU constants for the physical register file and its CDB/read-port fabric.
package idu_rf_prf_pkg;
  localparam int PREG_W      = 6;
  localparam int PREG_NUM    = 64;
  localparam int XLEN        = 64;
  localparam int RF_PIPE_NUM = 4;
  localparam int CDB_NUM     = 4;
  localparam int RD_PORT_NUM = RF_PIPE_NUM * 2;

  // CDB slot order is ascending write priority: a later slot overrides an earlier one.
  localparam int CDB_ALU = 0;
  localparam int CDB_MXU = 1;
  localparam int CDB_DIV = 2;
  localparam int CDB_LSU = 3;
endpackage

// File: rtl/idu_rf_prf_rdport.sv
// One combinational PRF read mux; preg 0 and invalid requests return zero.
module idu_rf_prf_rdport
  import idu_rf_prf_pkg::*;
(
  input  logic              rd_vld_i,
  input  logic [PREG_W-1:0] rd_preg_i,
  input  logic [XLEN-1:0]   prf_i [PREG_NUM],
  output logic [XLEN-1:0]   rd_value_o
);

  assign rd_value_o = (rd_vld_i && (rd_preg_i != '0)) ? prf_i[rd_preg_i] : '0;

endmodule

// File: rtl/idu_rf_prf.sv
// 64x64 physical register file: four CDB write ports, eight read ports, per-preg ready bits.
module idu_rf_prf
  import idu_rf_prf_pkg::*;
(
  input  logic                clk,
  input  logic                rst_clk,
  input  logic                rtu_global_flush,
  input  logic                exu_idu_rf_alu_cdb_vld,
  input  logic [PREG_W-1:0]   exu_idu_rf_alu_cdb_preg,
  input  logic [XLEN-1:0]     exu_idu_rf_alu_cdb_result,
  input  logic                exu_idu_rf_mxu_cdb_vld,
  input  logic [PREG_W-1:0]   exu_idu_rf_mxu_cdb_preg,
  input  logic [XLEN-1:0]     exu_idu_rf_mxu_cdb_result,
  input  logic                exu_idu_rf_div_cdb_vld,
  input  logic [PREG_W-1:0]   exu_idu_rf_div_cdb_preg,
  input  logic [XLEN-1:0]     exu_idu_rf_div_cdb_result,
  input  logic                exu_idu_rf_lsu_cdb_vld,
  input  logic [PREG_W-1:0]   exu_idu_rf_lsu_cdb_preg,
  input  logic [XLEN-1:0]     exu_idu_rf_lsu_cdb_result,
  input  logic                idu_prf_alloc_vld,
  input  logic [PREG_W-1:0]   idu_prf_alloc_preg,
  input  logic                x_rf_pipe0_preg_psrc1_vld,
  input  logic [PREG_W-1:0]   x_rf_pipe0_preg_psrc1,
  input  logic                x_rf_pipe0_preg_psrc2_vld,
  input  logic [PREG_W-1:0]   x_rf_pipe0_preg_psrc2,
  input  logic                x_rf_pipe1_preg_psrc1_vld,
  input  logic [PREG_W-1:0]   x_rf_pipe1_preg_psrc1,
  input  logic                x_rf_pipe1_preg_psrc2_vld,
  input  logic [PREG_W-1:0]   x_rf_pipe1_preg_psrc2,
  input  logic                x_rf_pipe2_preg_psrc1_vld,
  input  logic [PREG_W-1:0]   x_rf_pipe2_preg_psrc1,
  input  logic                x_rf_pipe2_preg_psrc2_vld,
  input  logic [PREG_W-1:0]   x_rf_pipe2_preg_psrc2,
  input  logic                x_rf_pipe3_preg_psrc1_vld,
  input  logic [PREG_W-1:0]   x_rf_pipe3_preg_psrc1,
  input  logic                x_rf_pipe3_preg_psrc2_vld,
  input  logic [PREG_W-1:0]   x_rf_pipe3_preg_psrc2,
  output logic [XLEN-1:0]     x_rf_pipe0_psrc1_value,
  output logic [XLEN-1:0]     x_rf_pipe0_psrc2_value,
  output logic [XLEN-1:0]     x_rf_pipe1_psrc1_value,
  output logic [XLEN-1:0]     x_rf_pipe1_psrc2_value,
  output logic [XLEN-1:0]     x_rf_pipe2_psrc1_value,
  output logic [XLEN-1:0]     x_rf_pipe2_psrc2_value,
  output logic [XLEN-1:0]     x_rf_pipe3_psrc1_value,
  output logic [XLEN-1:0]     x_rf_pipe3_psrc2_value,
  output logic [PREG_NUM-1:0] prf_preg_ready
);

  logic [XLEN-1:0]     prf_q   [PREG_NUM];
  logic [PREG_NUM-1:0] ready_q;
  logic [PREG_NUM-1:0] ready_d;
  logic [PREG_NUM-1:0] wr_en;
  logic [XLEN-1:0]     wr_data [PREG_NUM];

  logic                cdb_vld  [CDB_NUM];
  logic [PREG_W-1:0]   cdb_preg [CDB_NUM];
  logic [XLEN-1:0]     cdb_res  [CDB_NUM];

  logic                rd_vld   [RD_PORT_NUM];
  logic [PREG_W-1:0]   rd_preg  [RD_PORT_NUM];
  logic [XLEN-1:0]     rd_value [RD_PORT_NUM];

  assign cdb_vld[CDB_ALU]  = exu_idu_rf_alu_cdb_vld;
  assign cdb_preg[CDB_ALU] = exu_idu_rf_alu_cdb_preg;
  assign cdb_res[CDB_ALU]  = exu_idu_rf_alu_cdb_result;
  assign cdb_vld[CDB_MXU]  = exu_idu_rf_mxu_cdb_vld;
  assign cdb_preg[CDB_MXU] = exu_idu_rf_mxu_cdb_preg;
  assign cdb_res[CDB_MXU]  = exu_idu_rf_mxu_cdb_result;
  assign cdb_vld[CDB_DIV]  = exu_idu_rf_div_cdb_vld;
  assign cdb_preg[CDB_DIV] = exu_idu_rf_div_cdb_preg;
  assign cdb_res[CDB_DIV]  = exu_idu_rf_div_cdb_result;
  assign cdb_vld[CDB_LSU]  = exu_idu_rf_lsu_cdb_vld;
  assign cdb_preg[CDB_LSU] = exu_idu_rf_lsu_cdb_preg;
  assign cdb_res[CDB_LSU]  = exu_idu_rf_lsu_cdb_result;

  // Slots are applied in ascending priority, so lsu > div > mxu > alu on a collision.
  always_comb begin
    wr_en = '0;
    for (int i = 0; i < PREG_NUM; i++) wr_data[i] = '0;
    for (int p = 0; p < CDB_NUM; p++) begin
      if (cdb_vld[p] && (cdb_preg[p] != '0)) begin
        wr_en[cdb_preg[p]]   = 1'b1;
        wr_data[cdb_preg[p]] = cdb_res[p];
      end
    end
  end

  // Alloc clears after the CDB set so it wins; flush overrides both.
  always_comb begin
    ready_d = ready_q | wr_en;
    if (rtu_global_flush) begin
      ready_d = '1;
    end else if (idu_prf_alloc_vld && (idu_prf_alloc_preg != '0)) begin
      ready_d[idu_prf_alloc_preg] = 1'b0;
    end
    ready_d[0] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_clk) begin
    if (!rst_clk) begin
      ready_q <= '1;
    end else begin
      ready_q <= ready_d;
    end
  end

  always_ff @(posedge clk or negedge rst_clk) begin
    if (!rst_clk) begin
      for (int i = 0; i < PREG_NUM; i++) prf_q[i] <= '0;
    end else begin
      for (int i = 0; i < PREG_NUM; i++) begin
        if (wr_en[i]) prf_q[i] <= wr_data[i];
      end
    end
  end

  assign prf_preg_ready = ready_q;

  assign rd_vld[0] = x_rf_pipe0_preg_psrc1_vld;  assign rd_preg[0] = x_rf_pipe0_preg_psrc1;
  assign rd_vld[1] = x_rf_pipe0_preg_psrc2_vld;  assign rd_preg[1] = x_rf_pipe0_preg_psrc2;
  assign rd_vld[2] = x_rf_pipe1_preg_psrc1_vld;  assign rd_preg[2] = x_rf_pipe1_preg_psrc1;
  assign rd_vld[3] = x_rf_pipe1_preg_psrc2_vld;  assign rd_preg[3] = x_rf_pipe1_preg_psrc2;
  assign rd_vld[4] = x_rf_pipe2_preg_psrc1_vld;  assign rd_preg[4] = x_rf_pipe2_preg_psrc1;
  assign rd_vld[5] = x_rf_pipe2_preg_psrc2_vld;  assign rd_preg[5] = x_rf_pipe2_preg_psrc2;
  assign rd_vld[6] = x_rf_pipe3_preg_psrc1_vld;  assign rd_preg[6] = x_rf_pipe3_preg_psrc1;
  assign rd_vld[7] = x_rf_pipe3_preg_psrc2_vld;  assign rd_preg[7] = x_rf_pipe3_preg_psrc2;

  for (genvar k = 0; k < RD_PORT_NUM; k++) begin : g_rdport
    idu_rf_prf_rdport u_rdport (
      .rd_vld_i   (rd_vld[k]),
      .rd_preg_i  (rd_preg[k]),
      .prf_i      (prf_q),
      .rd_value_o (rd_value[k])
    );
  end

  assign x_rf_pipe0_psrc1_value = rd_value[0];
  assign x_rf_pipe0_psrc2_value = rd_value[1];
  assign x_rf_pipe1_psrc1_value = rd_value[2];
  assign x_rf_pipe1_psrc2_value = rd_value[3];
  assign x_rf_pipe2_psrc1_value = rd_value[4];
  assign x_rf_pipe2_psrc2_value = rd_value[5];
  assign x_rf_pipe3_psrc1_value = rd_value[6];
  assign x_rf_pipe3_psrc2_value = rd_value[7];

endmodule

// File: tb/tb_idu_rf_prf.sv
// Scoreboard bench for idu_rf_prf: stimulus queues expectations, a negedge monitor checks them.
module tb_idu_rf_prf;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        cdb_vld  [4];
  logic [5:0]  cdb_preg [4];
  logic [63:0] cdb_res  [4];
  logic        alloc_vld;
  logic [5:0]  alloc_preg;
  logic        rd_vld  [8];
  logic [5:0]  rd_preg [8];
  logic [63:0] rd_val  [8];
  logic [63:0] ready;

  typedef struct {
    int          cyc;
    int          kind;  // 0: read port value, 1: full ready vector, 2: single ready bit
    int          idx;
    logic [63:0] val;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  idu_rf_prf dut (
    .clk                        (clk),
    .rst_clk                    (rst_n),
    .rtu_global_flush           (flush),
    .exu_idu_rf_alu_cdb_vld     (cdb_vld[0]),
    .exu_idu_rf_alu_cdb_preg    (cdb_preg[0]),
    .exu_idu_rf_alu_cdb_result  (cdb_res[0]),
    .exu_idu_rf_mxu_cdb_vld     (cdb_vld[1]),
    .exu_idu_rf_mxu_cdb_preg    (cdb_preg[1]),
    .exu_idu_rf_mxu_cdb_result  (cdb_res[1]),
    .exu_idu_rf_div_cdb_vld     (cdb_vld[2]),
    .exu_idu_rf_div_cdb_preg    (cdb_preg[2]),
    .exu_idu_rf_div_cdb_result  (cdb_res[2]),
    .exu_idu_rf_lsu_cdb_vld     (cdb_vld[3]),
    .exu_idu_rf_lsu_cdb_preg    (cdb_preg[3]),
    .exu_idu_rf_lsu_cdb_result  (cdb_res[3]),
    .idu_prf_alloc_vld          (alloc_vld),
    .idu_prf_alloc_preg         (alloc_preg),
    .x_rf_pipe0_preg_psrc1_vld  (rd_vld[0]),
    .x_rf_pipe0_preg_psrc1      (rd_preg[0]),
    .x_rf_pipe0_preg_psrc2_vld  (rd_vld[1]),
    .x_rf_pipe0_preg_psrc2      (rd_preg[1]),
    .x_rf_pipe1_preg_psrc1_vld  (rd_vld[2]),
    .x_rf_pipe1_preg_psrc1      (rd_preg[2]),
    .x_rf_pipe1_preg_psrc2_vld  (rd_vld[3]),
    .x_rf_pipe1_preg_psrc2      (rd_preg[3]),
    .x_rf_pipe2_preg_psrc1_vld  (rd_vld[4]),
    .x_rf_pipe2_preg_psrc1      (rd_preg[4]),
    .x_rf_pipe2_preg_psrc2_vld  (rd_vld[5]),
    .x_rf_pipe2_preg_psrc2      (rd_preg[5]),
    .x_rf_pipe3_preg_psrc1_vld  (rd_vld[6]),
    .x_rf_pipe3_preg_psrc1      (rd_preg[6]),
    .x_rf_pipe3_preg_psrc2_vld  (rd_vld[7]),
    .x_rf_pipe3_preg_psrc2      (rd_preg[7]),
    .x_rf_pipe0_psrc1_value     (rd_val[0]),
    .x_rf_pipe0_psrc2_value     (rd_val[1]),
    .x_rf_pipe1_psrc1_value     (rd_val[2]),
    .x_rf_pipe1_psrc2_value     (rd_val[3]),
    .x_rf_pipe2_psrc1_value     (rd_val[4]),
    .x_rf_pipe2_psrc2_value     (rd_val[5]),
    .x_rf_pipe3_psrc1_value     (rd_val[6]),
    .x_rf_pipe3_psrc2_value     (rd_val[7]),
    .prf_preg_ready             (ready)
  );

  // Monitor: every expectation is due at the negedge of the cycle it was queued in.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t        e;
      logic [63:0] act;
      e = sb.pop_front();
      case (e.kind)
        0:       act = rd_val[e.idx];
        1:       act = ready;
        default: act = {63'b0, ready[e.idx]};
      endcase
      checks++;
      if (e.cyc != cyc) begin
        errors++;
        $display("FAIL %s: check stale (due cycle %0d, now %0d)", e.name, e.cyc, cyc);
      end else if (act !== e.val) begin
        errors++;
        $display("FAIL %s: got %h expected %h", e.name, act, e.val);
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
    flush     = 1'b0;
    alloc_vld = 1'b0;
    alloc_preg = '0;
    for (int i = 0; i < 4; i++) begin
      cdb_vld[i] = 1'b0; cdb_preg[i] = '0; cdb_res[i] = '0;
    end
    for (int i = 0; i < 8; i++) begin
      rd_vld[i] = 1'b0; rd_preg[i] = '0;
    end
  endtask

  task automatic cdb(input int unit, input logic [5:0] p, input logic [63:0] d);
    cdb_vld[unit] = 1'b1; cdb_preg[unit] = p; cdb_res[unit] = d;
  endtask

  task automatic rd(input int port, input logic vld, input logic [5:0] p,
                    input logic [63:0] expv, input string name);
    exp_t e;
    rd_vld[port] = vld; rd_preg[port] = p;
    e.cyc = cyc; e.kind = 0; e.idx = port; e.val = expv; e.name = name;
    sb.push_back(e);
  endtask

  task automatic rdy_all(input logic [63:0] expv, input string name);
    exp_t e;
    e.cyc = cyc; e.kind = 1; e.idx = 0; e.val = expv; e.name = name;
    sb.push_back(e);
  endtask

  task automatic rdy_bit(input int b, input logic expb, input string name);
    exp_t e;
    e.cyc = cyc; e.kind = 2; e.idx = b; e.val = {63'b0, expb}; e.name = name;
    sb.push_back(e);
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0; alloc_vld = 1'b0; alloc_preg = '0;
    for (int i = 0; i < 4; i++) begin
      cdb_vld[i] = 1'b0; cdb_preg[i] = '0; cdb_res[i] = '0;
    end
    for (int i = 0; i < 8; i++) begin
      rd_vld[i] = 1'b0; rd_preg[i] = '0;
    end

    // In reset: outputs forced, and a write attempted now must be discarded
    next_cycle();
    cdb(0, 6'd12, 64'h77);
    for (int p = 0; p < 8; p++) rd(p, 1'b1, 6'd5, 64'h0, "rst_read_p5");
    rdy_all('1, "rst_ready_all");

    next_cycle();
    rst_n = 1'b1;
    for (int p = 0; p < 8; p++) rd(p, 1'b1, 6'd5, 64'h0, "post_rst_read_p5");
    rdy_all('1, "post_rst_ready_all");

    // Alloc 7 at T
    next_cycle();
    alloc_vld = 1'b1; alloc_preg = 6'd7;

    // T+1: ready[7] cleared
    next_cycle();
    rdy_bit(7, 1'b0, "alloc7_ready");
    rdy_all(64'hFFFF_FFFF_FFFF_FF7F, "alloc7_ready_vec");
    rd(0, 1'b1, 6'd12, 64'h0, "rst_discard_p12");

    // T+2: alu writes; no same-cycle bypass
    next_cycle();
    cdb(0, 6'd7, 64'hDEAD_BEEF);
    rd(0, 1'b1, 6'd7, 64'h0, "p7_before_write");
    rd(5, 1'b1, 6'd7, 64'h0, "p7_before_write_p5");
    rdy_bit(7, 1'b0, "p7_ready_before_write");

    // T+3
    next_cycle();
    for (int p = 0; p < 8; p++) rd(p, 1'b1, 6'd7, 64'hDEAD_BEEF, "p7_after_write");
    rdy_bit(7, 1'b1, "p7_ready_after_write");

    // All four CDB ports at once
    next_cycle();
    cdb(0, 6'd1, 64'h11); cdb(1, 6'd2, 64'h22); cdb(2, 6'd3, 64'h33); cdb(3, 6'd4, 64'h44);

    next_cycle();
    rd(0, 1'b1, 6'd1, 64'h11, "alu_p1");
    rd(1, 1'b1, 6'd2, 64'h22, "mxu_p2");
    rd(2, 1'b1, 6'd3, 64'h33, "div_p3");
    rd(3, 1'b1, 6'd4, 64'h44, "lsu_p4");
    rd(4, 1'b0, 6'd4, 64'h0,  "invalid_read_p4");
    rd(5, 1'b1, 6'd7, 64'hDEAD_BEEF, "p7_persist");
    // Collisions: lsu beats alu, div beats mxu
    cdb(3, 6'd9, 64'hAA); cdb(0, 6'd9, 64'hBB);
    cdb(2, 6'd13, 64'hCC); cdb(1, 6'd13, 64'hDD);

    next_cycle();
    rd(0, 1'b1, 6'd9,  64'hAA, "collide_lsu_alu");
    rd(1, 1'b1, 6'd13, 64'hCC, "collide_div_mxu");
    // Writes to preg 0 are dropped
    cdb(1, 6'd0, 64'h5);

    next_cycle();
    rd(0, 1'b1, 6'd0, 64'h0, "p0_read_zero");
    rd(7, 1'b1, 6'd0, 64'h0, "p0_read_zero_p7");
    rdy_bit(0, 1'b1, "p0_ready");
    // Alloc and CDB write on the same preg: data lands, alloc wins on ready
    alloc_vld = 1'b1; alloc_preg = 6'd14;
    cdb(0, 6'd14, 64'h1414);

    next_cycle();
    rd(2, 1'b1, 6'd14, 64'h1414, "alloc_cdb_same_data");
    rdy_bit(14, 1'b0, "alloc_cdb_same_ready");
    alloc_vld = 1'b1; alloc_preg = 6'd10;

    next_cycle();
    alloc_vld = 1'b1; alloc_preg = 6'd11;
    rdy_bit(10, 1'b0, "alloc10_ready");

    // Flush cycle: alloc ignored, CDB write still lands
    next_cycle();
    rdy_bit(10, 1'b0, "alloc10_ready_pre_flush");
    rdy_bit(11, 1'b0, "alloc11_ready_pre_flush");
    flush = 1'b1;
    alloc_vld = 1'b1; alloc_preg = 6'd12;
    cdb(3, 6'd15, 64'hF0F0);

    next_cycle();
    rdy_all('1, "flush_ready_all");
    rd(3, 1'b1, 6'd15, 64'hF0F0, "flush_cycle_write");
    rd(6, 1'b1, 6'd14, 64'h1414, "p14_persist");

    // Async reset wipes contents
    next_cycle();
    #2;
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    rd(4, 1'b1, 6'd15, 64'h0, "rst_clears_p15");
    rd(5, 1'b1, 6'd1,  64'h0, "rst_clears_p1");
    rdy_all('1, "rst_ready_after_pulse");

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: %0d pending expected 0", sb.size());
    end
    @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/idu_rf_prf.md
IDU_RF_PRF -- requirements
Module: idu_rf_prf

Interface
REQ-001 clk  input  1  core clock; all state updates on rising edge.
REQ-002 rst_clk  input  1  asynchronous, active-low reset.
REQ-003 rtu_global_flush  input  1  pipeline flush from retire unit.
REQ-004 exu_idu_rf_{alu,mxu,div,lsu}_cdb_vld  input  1 each  CDB write valid, one write port per unit.
REQ-005 exu_idu_rf_{alu,mxu,div,lsu}_cdb_preg  input  6 each  CDB destination physical register.
REQ-006 exu_idu_rf_{alu,mxu,div,lsu}_cdb_result  input  64 each  CDB write data.
REQ-007 idu_prf_alloc_vld  input  1  dispatch allocates a new destination preg this cycle.
REQ-008 idu_prf_alloc_preg  input  6  allocated preg; its ready bit is cleared.
REQ-009 x_rf_pipeN_preg_psrc{1,2}_vld, N=0..3  input  1 each  read request valid from rf pipe N.
REQ-010 x_rf_pipeN_preg_psrc{1,2}, N=0..3  input  6 each  read address from rf pipe N.
REQ-011 x_rf_pipeN_psrc{1,2}_value, N=0..3  output  64 each  read data to rf pipe N.
REQ-012 prf_preg_ready  output  64  per-preg ready bit, bit i = preg i.

Function
REQ-013 Storage: 64 entries x 64 bits, indexed by 6-bit preg.
REQ-014 Preg 0 reads as 64'h0, ignores all writes, and its ready bit is always 1.
REQ-015 Reads are combinational from the stored array: value = array[addr] when the request is valid, 64'h0 when it is not.
REQ-016 No internal write-to-read bypass: a CDB write in cycle T is visible on reads from cycle T+1 (same-cycle forwarding is the rf pipe's job).
REQ-017 Each CDB port with vld=1 and preg!=0 writes result into array[preg] at the clock edge.
REQ-018 Two or more CDB ports targeting the same preg in one cycle is illegal; the RTL resolves it deterministically with priority lsu > div > mxu > alu.
REQ-019 Ready bit is set at the edge for every preg written by a valid CDB port.
REQ-020 Ready bit is cleared at the edge for idu_prf_alloc_preg when idu_prf_alloc_vld=1 and preg!=0.
REQ-021 Alloc and CDB write to the same preg in the same cycle: data is written and the ready bit ends cleared (alloc wins).
REQ-022 rtu_global_flush=1: all 64 ready bits are set at the edge and alloc is ignored that cycle.
REQ-023 CDB writes arriving in the flush cycle still update the array.
REQ-024 Read ports are fully independent; any number of ports may read the same preg in one cycle.

Reset
REQ-025 On rst_clk low: all array entries become 64'h0 and all ready bits become 1, asynchronously.
REQ-026 During reset, every read output is 64'h0 and prf_preg_ready is all-ones.
REQ-027 Reset asserted mid-write: the write is discarded; the entry reads 0 after reset release.

Structure
REQ-028 The shared idu package holds PREG_W=6, PREG_NUM=64, XLEN=64, RF_PIPE_NUM=4 and the CDB port count of 4.
REQ-029 A single sub-module, idu_rf_prf_rdport (one read mux with the preg-0 and vld masking), is instantiated 8 times.
REQ-030 The array and the ready vector live in the top module; there is no other hierarchy.

Verification
REQ-031 Reset release, then read all 8 ports at preg 5 -> all values 0; prf_preg_ready = 64'hFFFF_FFFF_FFFF_FFFF.
REQ-032 Alloc preg 7 at T -> ready[7]=0 at T+1; alu CDB writes 64'hDEAD_BEEF to preg 7 at T+2 -> reads return DEAD_BEEF at T+3 but still the old value in T+2, and ready[7]=1 at T+3.
REQ-033 alu, mxu, div and lsu write pregs 1, 2, 3 and 4 with 0x11, 0x22, 0x33 and 0x44 in the same cycle -> all four readable the next cycle.
REQ-034 lsu writes 0xAA and alu writes 0xBB to preg 9 in the same cycle -> reads return 0xAA.
REQ-035 mxu CDB writes 0x5 to preg 0 -> reads of preg 0 stay 0 and ready[0]=1.
REQ-036 Alloc pregs 10 and 11 -> ready[10]=0 and ready[11]=0; assert flush -> both ready bits are 1 the next cycle; alloc in the flush cycle has no effect.
